load_unit: RTL and testbench
============================

# load_unit

Load-side data-memory access unit, the read-path counterpart of the byte-store merge logic. It accepts one load request at a time from the execute stage and issues a word-aligned read to data memory. After a configurable memory latency it extracts the addressed byte or halfword, sign- or zero-extends it, and holds the 32-bit result under a valid/ready handshake to writeback. Lane mapping is little-endian and matches the store path: addr[1:0]=00 is bits [7:0] through addr[1:0]=11 is bits [31:24].

## Interface
- DM_LAT, 1, cycles from dm_re asserted to dm_out valid; legal range 1..4
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- ld_valid  in  1  load request present
- ld_ready  out  1  unit can accept a request; high only in IDLE
- ld_addr  in  10  byte address
- ld_type  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; other codes are illegal
- dm_re  out  1  one-cycle memory read strobe
- dm_addr  out  10  word-aligned address {ld_addr[9:2],2'b00}
- dm_out  in  32  memory read data
- rd_valid  out  1  result valid
- rd_ready  in  1  consumer accepts the result
- rd_data  out  32  extended load result
- ld_err  out  1  qualifies rd_valid: misaligned address or illegal ld_type

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - ld_ready=1.
  - On ld_valid, register addr and type.
  - Legal and aligned request -> ISSUE.
  - Misaligned or illegal request -> RESP with ld_err=1 and rd_data=0. No memory access occurs.
- Alignment rules:
  - lh/lhu requires addr[0]=0.
  - lw requires addr[1:0]=00.
  - lb/lbu is always aligned.
- ISSUE: dm_re=1 for exactly one cycle, dm_addr driven; load the latency counter with DM_LAT-1 -> WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter reads 0, dm_out is valid: capture the extracted result -> RESP.
- Extraction:
  - Byte: select lane addr[1:0].
  - Half: addr[1]=0 gives [15:0], addr[1]=1 gives [31:16].
  - Word: pass dm_out through.
  - lb/lh replicate the sign bit of the selected field into the upper bits; lbu/lhu fill the upper bits with zeros.
- RESP:
  - rd_valid=1; rd_data and ld_err stay stable until rd_valid&&rd_ready.
  - On that handshake -> IDLE.
- dm_addr holds its last value outside ISSUE. dm_re=0 in every state except ISSUE.
- Reset values:
  - State IDLE, dm_re=0, dm_addr=0.
  - rd_valid=0, rd_data=0, ld_err=0.
  - ld_ready=1 in the first cycle after reset.
- Reset mid-operation (ISSUE/WAIT/RESP) abandons the access. No rd_valid is produced for it, and any late dm_out is ignored.
- No request queueing: ld_valid while ld_ready=0 is ignored. The requester holds ld_valid until it sees ld_ready.

## Timing
- Request accepted at cycle T (ld_valid && ld_ready).
- dm_re=1 at T+1.
- dm_out is sampled at T+DM_LAT+1, and rd_valid rises at T+DM_LAT+2. With DM_LAT=1, rd_valid rises at T+3.
- Error path: rd_valid=1, ld_err=1 at T+1. dm_re never asserts.
- rd_ready held high: RESP lasts 1 cycle and the next request can be accepted at the following cycle. Back-to-back throughput is one load per DM_LAT+3 cycles.
- rd_ready low: the result is held indefinitely, with no change to rd_data or ld_err.
- Outputs are all registered except ld_ready, which is decoded from state.

## Structure
- Package `load_pkg` holds:
  - ld_type encodings LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU;
  - the state enum;
  - the DM_LAT bounds.
- Sub-module `load_extract`: combinational lane select plus sign/zero extension. Inputs are word, addr[1:0] and ld_type; output is data[31:0]. It is reused by a future forwarding path.
- The latency counter is 2 bits wide, sized for DM_LAT up to 4.

## Test plan
- lb from addr 0x003, dm_out=0x80FF_1234, DM_LAT=1 -> rd_data=0xFFFF_FF80; dm_addr=0x000; rd_valid at T+3.
- lbu from addr 0x001, same word -> 0x0000_0012. lhu from addr 0x002 -> 0x0000_80FF. lh from addr 0x002 -> 0xFFFF_80FF.
- lw from addr 0x006 -> ld_err=1, rd_data=0, rd_valid at T+1, dm_re never high. ld_type=011 -> same error response.
- lw from addr 0x010, dm_out=0xDEAD_BEEF, DM_LAT=3, rd_ready low for 5 cycles:
  - rd_data=0xDEAD_BEEF held stable throughout;
  - ld_ready=0 until the handshake completes, then 1 in the next cycle.
- rst asserted during WAIT -> next cycle: state IDLE, rd_valid=0, dm_re=0. The stale dm_out arrives and no response is produced.
- 20 random legal loads with rd_ready randomized, checked against a reference model:
  - one dm_re per load;
  - no lost or duplicated rd_valid handshakes.

Source files
------------

// File: rtl/load_pkg.sv
// Shared definitions for the load unit: load type encodings, FSM state
// encoding, memory latency bounds and small request-decoding helpers.
package load_pkg;

    // Memory latency range the 2-bit latency counter can cover.
    localparam int DM_LAT_MIN = 1;
    localparam int DM_LAT_MAX = 4;

    // Load type encodings as they arrive from the execute stage.
    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    // Access sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // True when the type code is one of the five defined loads.
    function automatic logic ld_type_legal(input logic [2:0] t);
        logic ok;
        ok = (t == LD_LB) || (t == LD_LH) || (t == LD_LW) ||
             (t == LD_LBU) || (t == LD_LHU);
        return ok;
    endfunction

    // Halfwords must sit on an even address, words on a multiple of four;
    // bytes are always aligned. Illegal types are rejected elsewhere.
    function automatic logic ld_is_aligned(input logic [2:0] t,
                                           input logic [1:0] a);
        logic ok;
        ok = 1'b1;
        if ((t == LD_LH) || (t == LD_LHU)) begin
            ok = ~a[0];
        end else if (t == LD_LW) begin
            ok = (a == 2'b00);
        end
        return ok;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Lane select plus sign/zero extension of a little-endian memory word.
// Purely combinational so that a forwarding path can share it later.
module load_extract
    import load_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_ld_type,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte lane and halfword from the word
    always_comb begin
        w_byte = 8'h00;
        case (i_addr)
            2'b00:   w_byte = i_word[7:0];
            2'b01:   w_byte = i_word[15:8];
            2'b10:   w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
    end

    // Extend the selected field to 32 bits according to the load type
    always_comb begin
        o_data = 32'h0000_0000;
        case (i_ld_type)
            LD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            LD_LBU:  o_data = {24'h000000, w_byte};
            LD_LH:   o_data = {{16{w_half[15]}}, w_half};
            LD_LHU:  o_data = {16'h0000, w_half};
            LD_LW:   o_data = i_word;
            default: o_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Load-side data-memory access unit. Accepts one load at a time, issues a
// single word-aligned read, waits out the memory latency, extracts and
// extends the addressed field and holds the result until writeback takes it.
// Misaligned or illegal requests are answered immediately with an error and
// never touch memory.
module load_unit
    import load_pkg::*;
#(
    parameter int DM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [9:0]  ld_addr,
    input  logic [2:0]  ld_type,
    output logic        dm_re,
    output logic [9:0]  dm_addr,
    input  logic [31:0] dm_out,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        ld_err
);

    // Counter start value; out-of-range latencies are clamped to the range
    // the 2-bit counter can represent.
    localparam int LAT_CLAMPED = (DM_LAT < DM_LAT_MIN) ? DM_LAT_MIN :
                                 (DM_LAT > DM_LAT_MAX) ? DM_LAT_MAX : DM_LAT;
    localparam logic [1:0] CNT_INIT = 2'(LAT_CLAMPED - 1);

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic [1:0]  r_addr_lo;
    logic [2:0]  r_type;
    logic        r_dm_re;
    logic [9:0]  r_dm_addr;
    logic        r_rd_valid;
    logic [31:0] r_rd_data;
    logic        r_ld_err;

    logic        w_req_ok;
    logic        w_cnt_done;
    logic [31:0] w_extract;

    assign ld_ready   = (r_state == ST_IDLE);
    assign w_req_ok   = ld_type_legal(ld_type) && ld_is_aligned(ld_type, ld_addr[1:0]);
    assign w_cnt_done = (r_cnt == 2'd0);

    assign dm_re    = r_dm_re;
    assign dm_addr  = r_dm_addr;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign ld_err   = r_ld_err;

    // Extraction works on the captured low address bits and type so the
    // request inputs are free to change once the load has been accepted.
    load_extract u_extract (
        .i_word    (dm_out),
        .i_addr    (r_addr_lo),
        .i_ld_type (r_type),
        .o_data    (w_extract)
    );

    // Request sequencing: accept, issue one read strobe, count down the
    // memory latency, then hold the response until the consumer takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 2'd0;
            r_addr_lo <= 2'b00;
            r_type    <= LD_LB;
            r_dm_re   <= 1'b0;
        end else begin
            r_dm_re <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (ld_valid) begin
                        r_addr_lo <= ld_addr[1:0];
                        r_type    <= ld_type;
                        if (w_req_ok) begin
                            r_state <= ST_ISSUE;
                            r_dm_re <= 1'b1;
                        end else begin
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= CNT_INIT;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_cnt_done) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                ST_RESP: begin
                    if (rd_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Memory address register: loaded only when a legal request is
    // accepted, otherwise it keeps the last issued address
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dm_addr <= 10'h000;
        end else if ((r_state == ST_IDLE) && ld_valid && w_req_ok) begin
            r_dm_addr <= {ld_addr[9:2], 2'b00};
        end
    end

    // Response registers: an error answer is set up straight from IDLE,
    // a data answer is captured in the cycle the memory word is valid,
    // and both stay frozen until the handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= 32'h0000_0000;
            r_ld_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ld_valid && !w_req_ok) begin
                        r_rd_valid <= 1'b1;
                        r_rd_data  <= 32'h0000_0000;
                        r_ld_err   <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (w_cnt_done) begin
                        r_rd_valid <= 1'b1;
                        r_rd_data  <= w_extract;
                        r_ld_err   <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (rd_ready) begin
                        r_rd_valid <= 1'b0;
                    end
                end
                default: begin
                    r_rd_valid <= r_rd_valid;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit. Two instances run side by side, one
// with a single-cycle memory and one with a three-cycle memory, each fed by
// its own behavioural memory that only presents real data in the cycle the
// latency says it is valid.
module tb_load_unit;
    import load_pkg::*;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        ld_valid [2];
    logic        ld_ready [2];
    logic [9:0]  ld_addr  [2];
    logic [2:0]  ld_type  [2];
    logic        dm_re    [2];
    logic [9:0]  dm_addr  [2];
    logic [31:0] dm_out   [2];
    logic        rd_valid [2];
    logic        rd_ready [2];
    logic [31:0] rd_data  [2];
    logic        ld_err   [2];

    logic [31:0] mem [0:255];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int dmre_cnt  [2] = '{0, 0};
    int dmre_last [2] = '{0, 0};
    int dmre_prev [2] = '{0, 0};
    int hs_cnt    [2] = '{0, 0};
    int dly       [2] = '{0, 0};
    logic [7:0] rd_idx [2] = '{8'h00, 8'h00};

    always #5 clk = ~clk;

    load_unit #(.DM_LAT(LAT0)) u_dut0 (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid[0]), .ld_ready(ld_ready[0]),
        .ld_addr(ld_addr[0]), .ld_type(ld_type[0]),
        .dm_re(dm_re[0]), .dm_addr(dm_addr[0]), .dm_out(dm_out[0]),
        .rd_valid(rd_valid[0]), .rd_ready(rd_ready[0]),
        .rd_data(rd_data[0]), .ld_err(ld_err[0])
    );

    load_unit #(.DM_LAT(LAT1)) u_dut1 (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid[1]), .ld_ready(ld_ready[1]),
        .ld_addr(ld_addr[1]), .ld_type(ld_type[1]),
        .dm_re(dm_re[1]), .dm_addr(dm_addr[1]), .dm_out(dm_out[1]),
        .rd_valid(rd_valid[1]), .rd_ready(rd_ready[1]),
        .rd_data(rd_data[1]), .ld_err(ld_err[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    // Expected load result computed from the lane rules with plain arithmetic
    function automatic logic [31:0] ref_load(input logic [31:0] w,
                                             input logic [9:0] a,
                                             input logic [2:0] t);
        longint v;
        int sh_b;
        int sh_h;
        sh_b = int'(a[1:0]) * 8;
        sh_h = int'(a[1]) * 16;
        v = 0;
        if (t == LD_LB || t == LD_LBU) begin
            v = longint'((w >> sh_b) & 32'h0000_00FF);
            if (t == LD_LB && v >= 128) v = v - 256;
        end else if (t == LD_LH || t == LD_LHU) begin
            v = longint'((w >> sh_h) & 32'h0000_FFFF);
            if (t == LD_LH && v >= 32768) v = v - 65536;
        end else if (t == LD_LW) begin
            v = longint'(w);
        end
        return v[31:0];
    endfunction

    // Cycle counter plus strobe and handshake bookkeeping
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (dm_re[d] === 1'b1) begin
                dmre_cnt[d]  <= dmre_cnt[d] + 1;
                dmre_prev[d] <= dmre_last[d];
                dmre_last[d] <= cyc;
            end
            if (rd_valid[d] === 1'b1 && rd_ready[d] === 1'b1)
                hs_cnt[d] <= hs_cnt[d] + 1;
        end
    end

    // Memory models: real data only in the cycle DM_LAT after the strobe,
    // random garbage in every other cycle
    always @(posedge clk) begin
        int nd;
        logic [7:0] ai;
        for (int d = 0; d < 2; d++) begin
            nd = dly[d];
            ai = rd_idx[d];
            if (dm_re[d] === 1'b1) begin
                nd = lat_of(d);
                ai = dm_addr[d][9:2];
            end else if (nd > 0) begin
                nd = nd - 1;
            end
            dly[d]    <= nd;
            rd_idx[d] <= ai;
            dm_out[d] <= (nd == 1) ? mem[ai] : $urandom;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one request and wait for the response to become valid.
    task automatic run_load(input int d, input logic [9:0] addr, input logic [2:0] typ,
                            output int lat, output logic [31:0] data, output logic err,
                            output logic [9:0] issued, output logic timeout);
        lat = 0;
        timeout = 1'b1;
        issued = 10'h3FF;
        for (int i = 0; i < 50 && ld_ready[d] !== 1'b1; i++) tick;
        ld_valid[d] = 1'b1;
        ld_addr[d]  = addr;
        ld_type[d]  = typ;
        for (int i = 0; i < 40; i++) begin
            tick;
            lat++;
            if (lat == 1) begin
                ld_valid[d] = 1'b0;
                issued = dm_addr[d];
            end
            if (rd_valid[d] === 1'b1) begin
                timeout = 1'b0;
                break;
            end
        end
        data = rd_data[d];
        err  = ld_err[d];
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ld_ready[d] !== 1'b1) begin errors++;
                $display("[TB] FAIL reset_ld_ready dut%0d got %b want 1", d, ld_ready[d]); end
            checks++;
            if (dm_re[d] !== 1'b0) begin errors++;
                $display("[TB] FAIL reset_dm_re dut%0d got %b want 0", d, dm_re[d]); end
            checks++;
            if (dm_addr[d] !== 10'h000) begin errors++;
                $display("[TB] FAIL reset_dm_addr dut%0d got %h want 000", d, dm_addr[d]); end
            checks++;
            if (rd_valid[d] !== 1'b0) begin errors++;
                $display("[TB] FAIL reset_rd_valid dut%0d got %b want 0", d, rd_valid[d]); end
            checks++;
            if (rd_data[d] !== 32'h0) begin errors++;
                $display("[TB] FAIL reset_rd_data dut%0d got %h want 0", d, rd_data[d]); end
            checks++;
            if (ld_err[d] !== 1'b0) begin errors++;
                $display("[TB] FAIL reset_ld_err dut%0d got %b want 0", d, ld_err[d]); end
        end
    endtask

    task automatic test_lanes;
        logic [9:0]  addrs [4] = '{10'h003, 10'h001, 10'h002, 10'h002};
        logic [2:0]  types [4] = '{LD_LB, LD_LBU, LD_LHU, LD_LH};
        logic [31:0] wants [4] = '{32'hFFFF_FF80, 32'h0000_0012, 32'h0000_80FF, 32'hFFFF_80FF};
        int lat; logic [31:0] data; logic err; logic [9:0] iss; logic to; int re0;
        mem[0] = 32'h80FF_1234;
        rd_ready[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            re0 = dmre_cnt[0];
            run_load(0, addrs[k], types[k], lat, data, err, iss, to);
            tick;
            checks++;
            if (to || data !== wants[k]) begin errors++;
                $display("[TB] FAIL lane_data%0d got %h want %h (timeout=%b)", k, data, wants[k], to); end
            checks++;
            if (lat != LAT0 + 2) begin errors++;
                $display("[TB] FAIL lane_latency%0d got %0d want %0d", k, lat, LAT0 + 2); end
            checks++;
            if (iss !== 10'h000 || err !== 1'b0) begin errors++;
                $display("[TB] FAIL lane_addr_err%0d got addr %h err %b want 000/0", k, iss, err); end
            checks++;
            if (dmre_cnt[0] - re0 != 1) begin errors++;
                $display("[TB] FAIL lane_dm_re_count%0d got %0d want 1", k, dmre_cnt[0] - re0); end
        end
    endtask

    task automatic test_errors;
        logic [9:0] addrs [3] = '{10'h006, 10'h004, 10'h001};
        logic [2:0] types [3] = '{LD_LW, 3'b011, LD_LH};
        int lat; logic [31:0] data; logic err; logic [9:0] iss; logic to; int re0;
        rd_ready[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            re0 = dmre_cnt[0];
            run_load(0, addrs[k], types[k], lat, data, err, iss, to);
            tick;
            tick;
            checks++;
            if (to || err !== 1'b1 || data !== 32'h0) begin errors++;
                $display("[TB] FAIL err_resp%0d got err %b data %h want 1/0", k, err, data); end
            checks++;
            if (lat != 1) begin errors++;
                $display("[TB] FAIL err_latency%0d got %0d want 1", k, lat); end
            checks++;
            if (dmre_cnt[0] != re0) begin errors++;
                $display("[TB] FAIL err_dm_re%0d got %0d strobes want 0", k, dmre_cnt[0] - re0); end
        end
    endtask

    task automatic test_hold;
        int lat; logic [31:0] data; logic err; logic [9:0] iss; logic to; int re0;
        mem[4] = 32'hDEAD_BEEF;
        rd_ready[1] = 1'b0;
        re0 = dmre_cnt[1];
        run_load(1, 10'h010, LD_LW, lat, data, err, iss, to);
        checks++;
        if (to || data !== 32'hDEAD_BEEF || err !== 1'b0) begin errors++;
            $display("[TB] FAIL hold_data got %h err %b want deadbeef/0", data, err); end
        checks++;
        if (lat != LAT1 + 2 || iss !== 10'h010) begin errors++;
            $display("[TB] FAIL hold_timing got lat %0d addr %h want %0d/010", lat, iss, LAT1 + 2); end
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++;
            if (rd_valid[1] !== 1'b1 || rd_data[1] !== 32'hDEAD_BEEF || ld_err[1] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_stable%0d got v%b %h e%b want 1 deadbeef 0",
                         i, rd_valid[1], rd_data[1], ld_err[1]);
            end
            checks++;
            if (ld_ready[1] !== 1'b0) begin errors++;
                $display("[TB] FAIL hold_ld_ready%0d got %b want 0", i, ld_ready[1]); end
        end
        rd_ready[1] = 1'b1;
        tick;
        checks++;
        if (ld_ready[1] !== 1'b1 || rd_valid[1] !== 1'b0) begin errors++;
            $display("[TB] FAIL hold_release got ready %b valid %b want 1/0", ld_ready[1], rd_valid[1]); end
        checks++;
        if (dmre_cnt[1] - re0 != 1) begin errors++;
            $display("[TB] FAIL hold_dm_re_count got %0d want 1", dmre_cnt[1] - re0); end
    endtask

    task automatic test_reset_mid;
        int hs0;
        mem[8] = 32'h1357_9BDF;
        rd_ready[1] = 1'b1;
        hs0 = hs_cnt[1];
        ld_valid[1] = 1'b1;
        ld_addr[1]  = 10'h020;
        ld_type[1]  = LD_LW;
        tick;
        ld_valid[1] = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if (rd_valid[1] !== 1'b0 || dm_re[1] !== 1'b0 || ld_ready[1] !== 1'b1) begin errors++;
            $display("[TB] FAIL midreset_state got valid %b re %b ready %b want 0/0/1",
                     rd_valid[1], dm_re[1], ld_ready[1]);
        end
        checks++;
        if (dm_addr[1] !== 10'h000) begin errors++;
            $display("[TB] FAIL midreset_dm_addr got %h want 000", dm_addr[1]); end
        for (int i = 0; i < 6; i++) begin
            tick;
            checks++;
            if (rd_valid[1] !== 1'b0) begin errors++;
                $display("[TB] FAIL midreset_no_resp%0d got %b want 0", i, rd_valid[1]); end
        end
        checks++;
        if (hs_cnt[1] != hs0) begin errors++;
            $display("[TB] FAIL midreset_handshakes got %0d want 0", hs_cnt[1] - hs0); end
    endtask

    task automatic test_back_to_back;
        int re0;
        int hs0;
        mem[0] = 32'h80FF_1234;
        rd_ready[0] = 1'b1;
        re0 = dmre_cnt[0];
        hs0 = hs_cnt[0];
        ld_valid[0] = 1'b1;
        ld_addr[0]  = 10'h001;
        ld_type[0]  = LD_LBU;
        repeat (12) tick;
        ld_valid[0] = 1'b0;
        repeat (6) tick;
        checks++;
        if (dmre_cnt[0] - re0 != 3) begin errors++;
            $display("[TB] FAIL b2b_loads got %0d want 3", dmre_cnt[0] - re0); end
        checks++;
        if (dmre_last[0] - dmre_prev[0] != LAT0 + 3) begin errors++;
            $display("[TB] FAIL b2b_spacing got %0d want %0d", dmre_last[0] - dmre_prev[0], LAT0 + 3); end
        checks++;
        if (hs_cnt[0] - hs0 != 3) begin errors++;
            $display("[TB] FAIL b2b_handshakes got %0d want 3", hs_cnt[0] - hs0); end
    endtask

    task automatic test_random;
        logic [2:0] legal [5] = '{LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU};
        int d; int lat; int re0; int hs0; logic done;
        logic [2:0] t; logic [9:0] a; logic [31:0] w; logic [31:0] exp;
        logic [31:0] data; logic err; logic [9:0] iss; logic to;
        for (int n = 0; n < 20; n++) begin
            d = int'($urandom_range(0, 1));
            t = legal[$urandom_range(0, 4)];
            a = 10'($urandom_range(0, 1023));
            if (t == LD_LH || t == LD_LHU) a[0] = 1'b0;
            if (t == LD_LW) a[1:0] = 2'b00;
            w = $urandom;
            mem[a[9:2]] = w;
            exp = ref_load(w, a, t);
            re0 = dmre_cnt[d];
            hs0 = hs_cnt[d];
            rd_ready[d] = 1'b0;
            run_load(d, a, t, lat, data, err, iss, to);
            checks++;
            if (to || lat != lat_of(d) + 2 || iss !== {a[9:2], 2'b00}) begin errors++;
                $display("[TB] FAIL rand_timing%0d got lat %0d addr %h want %0d/%h",
                         n, lat, iss, lat_of(d) + 2, {a[9:2], 2'b00});
            end
            done = 1'b0;
            for (int i = 0; i < 30 && !done; i++) begin
                checks++;
                if (rd_data[d] !== exp || ld_err[d] !== 1'b0) begin errors++;
                    $display("[TB] FAIL rand_data%0d got %h err %b want %h (type %b addr %h word %h)",
                             n, rd_data[d], ld_err[d], exp, t, a, w);
                end
                rd_ready[d] = (i == 29) ? 1'b1 : 1'($urandom_range(0, 1));
                tick;
                if (hs_cnt[d] != hs0) done = 1'b1;
            end
            rd_ready[d] = 1'b0;
            tick;
            tick;
            checks++;
            if (hs_cnt[d] - hs0 != 1 || rd_valid[d] !== 1'b0) begin errors++;
                $display("[TB] FAIL rand_handshake%0d got %0d handshakes valid %b want 1/0",
                         n, hs_cnt[d] - hs0, rd_valid[d]);
            end
            checks++;
            if (dmre_cnt[d] - re0 != 1) begin errors++;
                $display("[TB] FAIL rand_dm_re%0d got %0d want 1", n, dmre_cnt[d] - re0); end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            ld_valid[d] = 1'b0;
            ld_addr[d]  = 10'h000;
            ld_type[d]  = LD_LB;
            rd_ready[d] = 1'b1;
        end
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset;
        test_lanes;
        test_errors;
        test_hold;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
